div_seq: RTL and testbench

- Iterative radix-2 divide sequencer for DIV/DIVU in the execute stage.
- Latches the operands, runs a 32-iteration restoring division and stalls the pipeline while busy.
- Delivers the quotient for LO and the remainder for HI with a one-cycle ready pulse. The controller's hilowrite path then commits them.
- Sits beside the ALU, driven by the decoded div/signed_div control bits, with flushE feeding annul.

---
 rtl/div_seq.sv | 129 ++++++++++++
 tb/tb_div_seq.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/div_seq.sv
// rtl/div_seq.sv - iterative radix-2 restoring DIV/DIVU sequencer for the execute stage
// Optional build macro DIV_EARLY_OUT_EN: skip iterations when |a| < |b|.
module div_seq #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             annul,
    output logic             stall_div,
    output logic             busy,
    output logic             ready,
    output logic [WIDTH-1:0] quo,
    output logic [WIDTH-1:0] rem
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH:0]   prem_q, prem_d;
    logic             qneg_q, qneg_d;
    logic             rneg_q, rneg_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] rem_q, rem_d;

    logic [WIDTH-1:0] mag_a, mag_b;
    logic [WIDTH:0]   shifted, trial;

    assign mag_a = (signed_div && a[WIDTH-1]) ? -a : a;
    assign mag_b = (signed_div && b[WIDTH-1]) ? -b : b;

    // The dividend register doubles as the quotient: its MSB feeds the
    // remainder while each new quotient bit enters at the LSB.
    assign shifted = {prem_q[WIDTH-1:0], dvd_q[WIDTH-1]};
    assign trial   = shifted - {1'b0, dvs_q};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        prem_d  = prem_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        case (state_q)
            IDLE: begin
                if (start && !annul) begin
                    if (b == '0) begin
                        state_d = DONE;
                        quo_d   = '1;
                        rem_d   = a;
                    end
`ifdef DIV_EARLY_OUT_EN
                    else if (mag_a < mag_b) begin
                        state_d = DONE;
                        quo_d   = '0;
                        rem_d   = a;
                    end
`endif
                    else begin
                        state_d = BUSY;
                        dvd_d   = mag_a;
                        dvs_d   = mag_b;
                        qneg_d  = signed_div & (a[WIDTH-1] ^ b[WIDTH-1]);
                        rneg_d  = signed_div & a[WIDTH-1];
                        prem_d  = '0;
                        cnt_d   = '0;
                    end
                end
            end
            BUSY: begin
                if (annul) begin
                    state_d = IDLE;
                end else begin
                    prem_d = trial[WIDTH] ? shifted : trial;
                    dvd_d  = {dvd_q[WIDTH-2:0], ~trial[WIDTH]};
                    cnt_d  = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(WIDTH - 1)) begin
                        state_d = DONE;
                        quo_d   = qneg_q ? -dvd_d : dvd_d;
                        rem_d   = rneg_q ? -prem_d[WIDTH-1:0] : prem_d[WIDTH-1:0];
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            dvd_q   <= '0;
            dvs_q   <= '0;
            prem_q  <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            quo_q   <= '0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            prem_q  <= prem_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
        end
    end

    assign busy      = (state_q == BUSY);
    assign ready     = (state_q == DONE) && !annul;
    assign stall_div = ((state_q == IDLE) && start && !annul) || (state_q == BUSY);
    assign quo       = quo_q;
    assign rem       = rem_q;

endmodule

// File: tb/tb_div_seq.sv
// tb/tb_div_seq.sv - directed vector bench for div_seq
module tb_div_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        signed_div;
    logic [31:0] a;
    logic [31:0] b;
    logic        annul;
    logic        stall_div;
    logic        busy;
    logic        ready;
    logic [31:0] quo;
    logic [31:0] rem;

    int n_tests = 0;
    int n_fail  = 0;
    int ready_cnt = 0;

    div_seq #(.WIDTH(32), .CNT_W(5)) dut (
        .clk(clk), .rst(rst), .start(start), .signed_div(signed_div),
        .a(a), .b(b), .annul(annul), .stall_div(stall_div), .busy(busy),
        .ready(ready), .quo(quo), .rem(rem)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (ready === 1'b1) ready_cnt++;

`ifdef DIV_EARLY_OUT_EN
    localparam int EO_LAT = 1;
`else
    localparam int EO_LAT = 33;
`endif

    typedef struct {
        string       name;
        logic [31:0] a;
        logic [31:0] b;
        logic        sd;
        logic [31:0] q;
        logic [31:0] r;
        int          lat;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Caller is positioned just after a rising edge; that cycle is cycle 0.
    task automatic run_op(input string name, input logic [31:0] ta, input logic [31:0] tb_v,
                          input logic sd, input logic [31:0] eq, input logic [31:0] er,
                          input int elat, input bit keep);
        int got;
        int serr;
        int r0;
        logic [31:0] q_s;
        logic [31:0] r_s;
        a = ta; b = tb_v; signed_div = sd; start = 1'b1;
        got = -1; serr = 0; r0 = ready_cnt; q_s = 'x; r_s = 'x;
        for (int cyc = 0; cyc < 100; cyc++) begin
            @(negedge clk);
            if (stall_div !== (cyc < elat)) serr++;
            if (ready === 1'b1) begin
                got = cyc; q_s = quo; r_s = rem;
            end
            @(posedge clk); #1;
            if (got >= 0) break;
        end
        if (!keep) start = 1'b0;
        chk({name, " latency"}, got, elat);
        chk({name, " quo"}, q_s, eq);
        chk({name, " rem"}, r_s, er);
        chk({name, " stall errors"}, serr, 0);
        chk({name, " ready pulses"}, ready_cnt - r0, 1);
    endtask

    initial begin
        logic [31:0] last_q;
        logic [31:0] last_r;
        int bad;

        vecs[0]  = '{"divu 100/7",   32'd100,        32'd7,          1'b0, 32'd14,         32'd2,          33};
        vecs[1]  = '{"div -7/2",     32'hFFFFFFF9,   32'd2,          1'b1, 32'hFFFFFFFD,   32'hFFFFFFFF,   33};
        vecs[2]  = '{"div 7/-2",     32'd7,          32'hFFFFFFFE,   1'b1, 32'hFFFFFFFD,   32'd1,          33};
        vecs[3]  = '{"div ovf",      32'h80000000,   32'hFFFFFFFF,   1'b1, 32'h80000000,   32'd0,          33};
        vecs[4]  = '{"divu max/1",   32'hFFFFFFFF,   32'd1,          1'b0, 32'hFFFFFFFF,   32'd0,          33};
        vecs[5]  = '{"divu by 0",    32'h1234,       32'd0,          1'b0, 32'hFFFFFFFF,   32'h1234,       1};
        vecs[6]  = '{"divu 5/9",     32'd5,          32'd9,          1'b0, 32'd0,          32'd5,          EO_LAT};
        vecs[7]  = '{"div -100/7",   32'hFFFFFF9C,   32'd7,          1'b1, 32'hFFFFFFF2,   32'hFFFFFFFE,   33};
        vecs[8]  = '{"divu big/2",   32'hFFFFFFF9,   32'd2,          1'b0, 32'h7FFFFFFC,   32'd1,          33};
        vecs[9]  = '{"div -5/9",     32'hFFFFFFFB,   32'd9,          1'b1, 32'd0,          32'hFFFFFFFB,   EO_LAT};
        vecs[10] = '{"div by 0 neg", 32'hFFFFFFF0,   32'd0,          1'b1, 32'hFFFFFFFF,   32'hFFFFFFF0,   1};

        rst = 1'b1; start = 1'b0; signed_div = 1'b0; a = '0; b = '0; annul = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset quo", quo, 32'd0);
        chk("reset rem", rem, 32'd0);
        chk("reset busy/ready/stall", {busy, ready, stall_div}, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 11; i++) begin
            run_op(vecs[i].name, vecs[i].a, vecs[i].b, vecs[i].sd,
                   vecs[i].q, vecs[i].r, vecs[i].lat, 1'b0);
            @(posedge clk); #1;
        end
        last_q = vecs[10].q;
        last_r = vecs[10].r;

        // Annul in cycle 10: back to IDLE, no ready, results untouched.
        a = 32'd100; b = 32'd7; signed_div = 1'b0; start = 1'b1;
        repeat (10) @(posedge clk);
        #1; annul = 1'b1;
        @(negedge clk);
        chk("annul cycle busy", busy, 1'b1);
        @(posedge clk); #1;
        annul = 1'b0; start = 1'b0;
        @(negedge clk);
        chk("annul idle busy", busy, 1'b0);
        bad = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (ready !== 1'b0 || busy !== 1'b0) bad++;
        end
        chk("annul no ready", bad, 0);
        chk("annul quo kept", quo, last_q);
        chk("annul rem kept", rem, last_r);
        @(posedge clk); #1;

        // Reset in cycle 5 of a divide.
        a = 32'd100; b = 32'd7; signed_div = 1'b0; start = 1'b1;
        repeat (5) @(posedge clk);
        #1; rst = 1'b1; start = 1'b0;
        @(posedge clk); #1;
        chk("midrst quo", quo, 32'd0);
        chk("midrst rem", rem, 32'd0);
        chk("midrst busy/ready/stall", {busy, ready, stall_div}, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Start held through DONE, then a back-to-back divide in cycle 34.
        run_op("hold 100/7", 32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 33, 1'b1);
        run_op("b2b 9/3", 32'd9, 32'd3, 1'b0, 32'd3, 32'd0, 33, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
